// File: rtl/display_timing_gen_if.sv
// Raster timing bundle: the run enable going in, counters, decodes and strobes coming out.
interface display_timing_gen_if #(
  parameter int HCOUNT_WIDTH = 10,
  parameter int VCOUNT_WIDTH = 10
);
  logic                    enable;
  logic                    pixel_en;
  logic [HCOUNT_WIDTH-1:0] h_pos;
  logic [VCOUNT_WIDTH-1:0] v_pos;
  logic [HCOUNT_WIDTH-1:0] x;
  logic [VCOUNT_WIDTH-1:0] y;
  logic                    hsync;
  logic                    vsync;
  logic                    hblank;
  logic                    vblank;
  logic                    active;
  logic                    line_start;
  logic                    frame_start;
  logic                    vblank_start;

  modport master (
    input  enable,
    output pixel_en, h_pos, v_pos, x, y, hsync, vsync, hblank, vblank, active,
           line_start, frame_start, vblank_start
  );

  modport slave (
    output enable,
    input  pixel_en, h_pos, v_pos, x, y, hsync, vsync, hblank, vblank, active,
           line_start, frame_start, vblank_start
  );
endinterface

// File: rtl/display_timing_gen.sv
// Parametrised raster timing generator clocked from clk with a pixel clock-enable divider.
// Line/frame order is sync, back porch, active, front porch; all decodes are combinational.
module display_timing_gen #(
  parameter int HCOUNT_WIDTH = 10,
  parameter int VCOUNT_WIDTH = 10,
  parameter int CLK_DIV      = 2,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int H_ACTIVE     = 640,
  parameter int H_FRONT      = 16,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int V_ACTIVE     = 480,
  parameter int V_FRONT      = 10,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0
) (
  input  logic                  clk,
  input  logic                  _reset,
  display_timing_gen_if.master  tif
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL - 1 >= (1 << HCOUNT_WIDTH)) begin : g_bad_hwidth
    $error("display_timing_gen: H_TOTAL-1 does not fit in HCOUNT_WIDTH");
  end
  if (V_TOTAL - 1 >= (1 << VCOUNT_WIDTH)) begin : g_bad_vwidth
    $error("display_timing_gen: V_TOTAL-1 does not fit in VCOUNT_WIDTH");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("display_timing_gen: CLK_DIV must be at least 1");
  end

  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HCOUNT_WIDTH-1:0] H_LAST   = HCOUNT_WIDTH'(H_TOTAL - 1);
  localparam logic [VCOUNT_WIDTH-1:0] V_LAST   = VCOUNT_WIDTH'(V_TOTAL - 1);
  localparam logic [HCOUNT_WIDTH-1:0] H_ORIGIN = HCOUNT_WIDTH'(H_SYNC + H_BACK);
  localparam logic [VCOUNT_WIDTH-1:0] V_ORIGIN = VCOUNT_WIDTH'(V_SYNC + V_BACK);

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [HCOUNT_WIDTH-1:0] h_pos_q,   h_pos_d;
  logic [VCOUNT_WIDTH-1:0] v_pos_q,   v_pos_d;
  logic                    div_last;
  logic [31:0]             h_w, v_w;

  assign div_last = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    h_pos_d   = h_pos_q;
    v_pos_d   = v_pos_q;
    if (!tif.enable) begin
      div_cnt_d = '0;
      h_pos_d   = '0;
      v_pos_d   = '0;
    end else begin
      div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
      if (div_last) begin
        if (h_pos_q == H_LAST) begin
          h_pos_d = '0;
          v_pos_d = (v_pos_q == V_LAST) ? '0 : v_pos_q + 1'b1;
        end else begin
          h_pos_d = h_pos_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      div_cnt_q <= '0;
      h_pos_q   <= '0;
      v_pos_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_pos_q   <= h_pos_d;
      v_pos_q   <= v_pos_d;
    end
  end

  // Widen the counters once so every region compare is done at 32 bits.
  assign h_w = 32'(h_pos_q);
  assign v_w = 32'(v_pos_q);

  // _reset gates the strobe so nothing fires while reset is held, even with CLK_DIV=1.
  assign tif.pixel_en     = tif.enable & div_last & _reset;
  assign tif.h_pos        = h_pos_q;
  assign tif.v_pos        = v_pos_q;
  assign tif.hsync        = (h_w < 32'(H_SYNC)) ? HSYNC_POL : ~HSYNC_POL;
  assign tif.vsync        = (v_w < 32'(V_SYNC)) ? VSYNC_POL : ~VSYNC_POL;
  assign tif.hblank       = (h_w < 32'(H_SYNC + H_BACK)) |
                            (h_w >= 32'(H_SYNC + H_BACK + H_ACTIVE));
  assign tif.vblank       = (v_w < 32'(V_SYNC + V_BACK)) |
                            (v_w >= 32'(V_SYNC + V_BACK + V_ACTIVE));
  assign tif.active       = ~tif.hblank & ~tif.vblank;
  assign tif.x            = tif.active ? h_pos_q - H_ORIGIN : '0;
  assign tif.y            = tif.active ? v_pos_q - V_ORIGIN : '0;
  assign tif.line_start   = tif.pixel_en & (h_pos_q == '0);
  assign tif.frame_start  = tif.line_start & (v_pos_q == '0);
  assign tif.vblank_start = tif.line_start &
                            (v_w == 32'(V_SYNC + V_BACK + V_ACTIVE));
endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: three geometries (default, tiny CLK_DIV=1, small CLK_DIV=3)
// checked every clk against a behavioural model through an expected-value queue.
module tb_display_timing_gen;
  typedef struct {
    int cd, hs, hb, ha, hf, vs, vb, va, vf;
    bit hp, vp;
  } cfg_t;

  typedef struct packed {
    logic [15:0] h, v, x, y;
    logic pe, hs, vs, hb, vb, act, ls, fs, vbs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en [3];

  cfg_t cfg [3];
  int   m_div [3];
  int   m_h [3];
  int   m_v [3];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  display_timing_gen_if #(.HCOUNT_WIDTH(10), .VCOUNT_WIDTH(10)) if_def ();
  display_timing_gen_if #(.HCOUNT_WIDTH(4),  .VCOUNT_WIDTH(3))  if_sml ();
  display_timing_gen_if #(.HCOUNT_WIDTH(10), .VCOUNT_WIDTH(10)) if_med ();

  assign if_def.enable = en[0];
  assign if_sml.enable = en[1];
  assign if_med.enable = en[2];

  display_timing_gen u_def (.clk(clk), ._reset(rst_n), .tif(if_def));

  display_timing_gen #(
    .HCOUNT_WIDTH(4), .VCOUNT_WIDTH(3), .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .H_SYNC(2), .H_BACK(2), .H_ACTIVE(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1)
  ) u_sml (.clk(clk), ._reset(rst_n), .tif(if_sml));

  display_timing_gen #(
    .CLK_DIV(3),
    .H_SYNC(3), .H_BACK(2), .H_ACTIVE(5), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(2)
  ) u_med (.clk(clk), ._reset(rst_n), .tif(if_med));

  function automatic exp_t predict(int i, bit rst);
    cfg_t c;
    exp_t e;
    int   h, v;
    bit   pe, hb, vb, act;
    c   = cfg[i];
    h   = m_h[i];
    v   = m_v[i];
    pe  = rst && (en[i] === 1'b1) && (m_div[i] == c.cd - 1);
    hb  = (h < c.hs + c.hb) || (h >= c.hs + c.hb + c.ha);
    vb  = (v < c.vs + c.vb) || (v >= c.vs + c.vb + c.va);
    act = !hb && !vb;
    e.h   = 16'(h);
    e.v   = 16'(v);
    e.x   = act ? 16'(h - c.hs - c.hb) : 16'd0;
    e.y   = act ? 16'(v - c.vs - c.vb) : 16'd0;
    e.pe  = pe;
    e.hs  = (h < c.hs) ? c.hp : !c.hp;
    e.vs  = (v < c.vs) ? c.vp : !c.vp;
    e.hb  = hb;
    e.vb  = vb;
    e.act = act;
    e.ls  = pe && (h == 0);
    e.fs  = pe && (h == 0) && (v == 0);
    e.vbs = pe && (h == 0) && (v == c.vs + c.vb + c.va);
    return e;
  endfunction

  function automatic exp_t get_obs(int i);
    exp_t o;
    case (i)
      0: o = {16'(if_def.h_pos), 16'(if_def.v_pos), 16'(if_def.x), 16'(if_def.y),
              if_def.pixel_en, if_def.hsync, if_def.vsync, if_def.hblank, if_def.vblank,
              if_def.active, if_def.line_start, if_def.frame_start, if_def.vblank_start};
      1: o = {16'(if_sml.h_pos), 16'(if_sml.v_pos), 16'(if_sml.x), 16'(if_sml.y),
              if_sml.pixel_en, if_sml.hsync, if_sml.vsync, if_sml.hblank, if_sml.vblank,
              if_sml.active, if_sml.line_start, if_sml.frame_start, if_sml.vblank_start};
      default: o = {16'(if_med.h_pos), 16'(if_med.v_pos), 16'(if_med.x), 16'(if_med.y),
              if_med.pixel_en, if_med.hsync, if_med.vsync, if_med.hblank, if_med.vblank,
              if_med.active, if_med.line_start, if_med.frame_start, if_med.vblank_start};
    endcase
    return o;
  endfunction

  // Advance the model on the clock edge and queue what each DUT must show afterwards.
  task automatic tick();
    int ht, vt;
    bit pe;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      ht = cfg[i].hs + cfg[i].hb + cfg[i].ha + cfg[i].hf;
      vt = cfg[i].vs + cfg[i].vb + cfg[i].va + cfg[i].vf;
      if (rst_n !== 1'b1 || en[i] !== 1'b1) begin
        m_div[i] = 0; m_h[i] = 0; m_v[i] = 0;
      end else begin
        pe = (m_div[i] == cfg[i].cd - 1);
        m_div[i] = pe ? 0 : m_div[i] + 1;
        if (pe) begin
          if (m_h[i] == ht - 1) begin
            m_h[i] = 0;
            m_v[i] = (m_v[i] == vt - 1) ? 0 : m_v[i] + 1;
          end else begin
            m_h[i] = m_h[i] + 1;
          end
        end
      end
      sb.push_back(predict(i, rst_n === 1'b1));
    end
  endtask

  task automatic test_reset();
    exp_t o, e;
    en[0] = 1'b1; en[1] = 1'b1; en[2] = 1'b1;
    rst_n = 1'b0;
    repeat (5) begin
      tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        o = get_obs(i); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL reset dut%0d: got h=%0d v=%0d x=%0d y=%0d flags=%b, expected h=%0d v=%0d x=%0d y=%0d flags=%b",
                   i, o.h, o.v, o.x, o.y, o[8:0], e.h, e.v, e.x, e.y, e[8:0]);
        end
      end
    end
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      o = get_obs(i); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset_release dut%0d: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                 i, o.h, o.v, o[8:0], e.h, e.v, e[8:0]);
      end
    end
    n_cmp++;
    if (if_def.pixel_en !== 1'b1 || if_def.frame_start !== 1'b1) begin
      n_bad++;
      $display("FAIL first_pixel: got pixel_en=%b frame_start=%b, expected 1 1",
               if_def.pixel_en, if_def.frame_start);
    end
  endtask

  task automatic test_default_line();
    exp_t o, e;
    int ls_cnt = 0;
    for (int t = 0; t < 1700; t++) begin
      tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        o = get_obs(i); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL default_line dut%0d t=%0d: got h=%0d v=%0d x=%0d y=%0d flags=%b, expected h=%0d v=%0d x=%0d y=%0d flags=%b",
                   i, t, o.h, o.v, o.x, o.y, o[8:0], e.h, e.v, e.x, e.y, e[8:0]);
        end
      end
      if (t >= 100 && if_def.line_start === 1'b1) ls_cnt++;
      if (m_h[0] == 95 || m_h[0] == 96) begin
        n_cmp++;
        if (if_def.hsync !== (m_h[0] == 96)) begin
          n_bad++;
          $display("FAIL hsync_edge: h=%0d got hsync=%b", m_h[0], if_def.hsync);
        end
      end
      if (m_h[0] == 143 || m_h[0] == 144 || m_h[0] == 783 || m_h[0] == 784) begin
        n_cmp++;
        if (if_def.hblank !== (m_h[0] == 143 || m_h[0] == 784)) begin
          n_bad++;
          $display("FAIL hblank_edge: h=%0d got hblank=%b", m_h[0], if_def.hblank);
        end
      end
    end
    n_cmp++;
    if (ls_cnt != 1) begin
      n_bad++;
      $display("FAIL line_start_rate: got %0d strobes in 1600 clks, expected 1", ls_cnt);
    end
  endtask

  task automatic test_small_cfg();
    exp_t o, e;
    int fs_cnt = 0, first_t = -1, last_t = -1;
    for (int t = 0; t < 600; t++) begin
      tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        o = get_obs(i); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL small_cfg dut%0d t=%0d: got h=%0d v=%0d x=%0d y=%0d flags=%b, expected h=%0d v=%0d x=%0d y=%0d flags=%b",
                   i, t, o.h, o.v, o.x, o.y, o[8:0], e.h, e.v, e.x, e.y, e[8:0]);
        end
      end
      if (if_sml.frame_start === 1'b1) begin
        fs_cnt++;
        if (first_t < 0) first_t = t;
        last_t = t;
      end
    end
    n_cmp++;
    if (fs_cnt != 10 || last_t - first_t != 540) begin
      n_bad++;
      $display("FAIL small_frame_rate: got %0d frame_starts spanning %0d clks, expected 10 spanning 540",
               fs_cnt, last_t - first_t);
    end
  endtask

  task automatic test_frame();
    exp_t o, e;
    int fs_cnt = 0, vbs_cnt = 0;
    for (int t = 0; t < 648; t++) begin
      tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        o = get_obs(i); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL frame dut%0d t=%0d: got h=%0d v=%0d x=%0d y=%0d flags=%b, expected h=%0d v=%0d x=%0d y=%0d flags=%b",
                   i, t, o.h, o.v, o.x, o.y, o[8:0], e.h, e.v, e.x, e.y, e[8:0]);
        end
      end
      if (if_med.frame_start === 1'b1) fs_cnt++;
      if (if_med.vblank_start === 1'b1) begin
        vbs_cnt++;
        n_cmp++;
        if (if_med.v_pos !== 10'd7 || if_med.h_pos !== 10'd0) begin
          n_bad++;
          $display("FAIL vblank_start_pos: got h=%0d v=%0d, expected h=0 v=7", if_med.h_pos, if_med.v_pos);
        end
      end
    end
    n_cmp++;
    if (fs_cnt != 2 || vbs_cnt != 2) begin
      n_bad++;
      $display("FAIL frame_rate: got frame_start=%0d vblank_start=%0d in 648 clks, expected 2 2",
               fs_cnt, vbs_cnt);
    end
  endtask

  task automatic test_enable_drop();
    exp_t o, e;
    bit found = 0;
    for (int t = 0; t < 400 && !found; t++) begin
      tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        o = get_obs(i); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL enable_seek dut%0d: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                   i, o.h, o.v, o[8:0], e.h, e.v, e[8:0]);
        end
      end
      if (m_h[2] == 6 && m_v[2] == 4) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL enable_seek_timeout: got no h=6 v=4 within 400 clks, expected it");
    end
    en[2] = 1'b0;
    repeat (3) begin
      tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        o = get_obs(i); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL enable_low dut%0d: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                   i, o.h, o.v, o[8:0], e.h, e.v, e[8:0]);
        end
      end
      n_cmp++;
      if (if_med.h_pos !== 10'd0 || if_med.v_pos !== 10'd0 || if_med.pixel_en !== 1'b0) begin
        n_bad++;
        $display("FAIL enable_clear: got h=%0d v=%0d pixel_en=%b, expected 0 0 0",
                 if_med.h_pos, if_med.v_pos, if_med.pixel_en);
      end
    end
    en[2] = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        o = get_obs(i); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL reenable dut%0d: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                   i, o.h, o.v, o[8:0], e.h, e.v, e[8:0]);
        end
      end
      n_cmp++;
      if (if_med.frame_start !== (k == 2)) begin
        n_bad++;
        $display("FAIL reenable_frame_start: clk %0d got %b, expected %b", k, if_med.frame_start, k == 2);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t o, e;
    bit found = 0;
    for (int t = 0; t < 400 && !found; t++) begin
      tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        o = get_obs(i); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL async_seek dut%0d: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                   i, o.h, o.v, o[8:0], e.h, e.v, e[8:0]);
        end
      end
      if (m_v[2] == 5) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL async_seek_timeout: got no v=5 within 400 clks, expected it");
    end
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_div[i] = 0; m_h[i] = 0; m_v[i] = 0;
      sb.push_back(predict(i, 1'b0));
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      o = get_obs(i); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL async_clear dut%0d: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                 i, o.h, o.v, o[8:0], e.h, e.v, e[8:0]);
      end
    end
    repeat (2) begin
      tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        o = get_obs(i); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL async_hold dut%0d: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                   i, o.h, o.v, o[8:0], e.h, e.v, e[8:0]);
        end
      end
    end
    rst_n = 1'b1;
    for (int t = 0; t < 300; t++) begin
      tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        o = get_obs(i); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL async_restart dut%0d t=%0d: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                   i, t, o.h, o.v, o[8:0], e.h, e.v, e[8:0]);
        end
      end
      if (t == 0) begin
        n_cmp++;
        if (if_def.frame_start !== 1'b1) begin
          n_bad++;
          $display("FAIL restart_first_pixel: got frame_start=%b, expected 1", if_def.frame_start);
        end
      end
    end
  endtask

  initial begin
    cfg[0] = '{cd: 2, hs: 96, hb: 48, ha: 640, hf: 16, vs: 2, vb: 33, va: 480, vf: 10, hp: 1'b0, vp: 1'b0};
    cfg[1] = '{cd: 1, hs: 2,  hb: 2,  ha: 4,   hf: 2,  vs: 1, vb: 1,  va: 3,   vf: 1,  hp: 1'b1, vp: 1'b1};
    cfg[2] = '{cd: 3, hs: 3,  hb: 2,  ha: 5,   hf: 2,  vs: 1, vb: 2,  va: 4,   vf: 2,  hp: 1'b0, vp: 1'b0};
    for (int i = 0; i < 3; i++) begin
      m_div[i] = 0; m_h[i] = 0; m_v[i] = 0;
      en[i] = 1'b1;
    end
    test_reset();
    test_default_line();
    test_small_cfg();
    test_frame();
    test_enable_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/display_timing_gen.md
Name: display_timing_gen

Overview:
- Parametrised raster timing generator for the video path; successor to the fixed 640x480@60 display controller.
- Generates horizontal/vertical scan counters, sync, blanking, active-area coordinates and frame/line event strobes.
- Runs entirely in the system clock domain using a pixel clock-enable divider, so no derived clock is needed.
- Timing, sync polarity and divider ratio are set by parameters. Feeds the pixel fetch/compositing logic and the VGA output pins.

Parameters:
HCOUNT_WIDTH, 10, width of h_pos and x
VCOUNT_WIDTH, 10, width of v_pos and y
CLK_DIV, 2, system clocks per pixel; minimum 1
H_SYNC, 96, hsync pulse length in pixels
H_BACK, 48, horizontal back porch in pixels
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch in pixels
V_SYNC, 2, vsync pulse length in lines
V_BACK, 33, vertical back porch in lines
V_ACTIVE, 480, visible lines
V_FRONT, 10, vertical front porch in lines
HSYNC_POL, 0, asserted level of hsync
VSYNC_POL, 0, asserted level of vsync

Ports:
clk  input  1  system clock
_reset  input  1  asynchronous active-low reset
enable  input  1  run the generator; when low, counters clear to zero and hold there
pixel_en  output  1  one-clk strobe marking each pixel advance
h_pos  output  HCOUNT_WIDTH  raw horizontal counter, 0..H_TOTAL-1
v_pos  output  VCOUNT_WIDTH  raw vertical counter, 0..V_TOTAL-1
x  output  HCOUNT_WIDTH  active-area column; 0 outside the active area
y  output  VCOUNT_WIDTH  active-area row; 0 outside the active area
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
hblank  output  1  horizontal blanking
vblank  output  1  vertical blanking
active  output  1  visible pixel: ~hblank & ~vblank
line_start  output  1  pixel_en & (h_pos==0)
frame_start  output  1  pixel_en & (h_pos==0) & (v_pos==0)
vblank_start  output  1  pixel_en & (h_pos==0) & (v_pos==V_SYNC+V_BACK+V_ACTIVE)

Behaviour:
- Totals: H_TOTAL = sum of the four H_* parameters; V_TOTAL = sum of the four V_* parameters.
- Elaboration must fail if H_TOTAL-1 does not fit in HCOUNT_WIDTH, if V_TOTAL-1 does not fit in VCOUNT_WIDTH, or if CLK_DIV < 1.
- Reset (_reset low, asynchronous):
  - div_cnt, h_pos and v_pos go to 0.
  - pixel_en, line_start, frame_start and vblank_start are forced to 0 while _reset is low, including when CLK_DIV=1.
  - Decoded outputs therefore take: hsync=HSYNC_POL, vsync=VSYNC_POL, hblank=1, vblank=1, active=0, x=0, y=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 on each clk while enable=1, then wraps.
  - pixel_en = enable & (div_cnt==CLK_DIV-1) & _reset.
  - With CLK_DIV=1, pixel_en equals enable.
- Counters advance only on a clk edge where pixel_en=1:
  - h_pos increments.
  - At h_pos==H_TOTAL-1, h_pos goes to 0 and v_pos increments.
  - At v_pos==V_TOTAL-1 together with h_pos wrap, v_pos goes to 0.
- Line order is sync, back porch, active, front porch (vertical uses the same order):
  - hsync = HSYNC_POL when h_pos < H_SYNC, else ~HSYNC_POL.
  - hblank = (h_pos < H_SYNC+H_BACK) | (h_pos >= H_SYNC+H_BACK+H_ACTIVE).
  - vsync and vblank are the same functions of v_pos with the V_* parameters.
- Coordinates:
  - When active=1: x = h_pos-(H_SYNC+H_BACK) and y = v_pos-(V_SYNC+V_BACK).
  - When active=0: x and y are 0.
- Latency: all decoded outputs and strobes are combinational from the registered counters. They change in the same cycle as h_pos/v_pos, with zero added latency.
- Each strobe is high for exactly one clk per event, and only in a cycle where pixel_en=1.
- enable=0:
  - On the next clk edge, div_cnt, h_pos and v_pos clear to 0, and pixel_en is 0.
  - After enable returns to 1, the first pixel_en occurs CLK_DIV clks later; it coincides with frame_start.
- Reset asserted mid-frame clears everything immediately, with no completion of the current line.

Test Plan:
- Reset/defaults: hold _reset low for 5 clks, then release with enable=1.
  - During reset: h_pos=0, v_pos=0, hsync=0, vsync=0, hblank=1, vblank=1, active=0, pixel_en=0.
  - After release: first pixel_en on clk 2, with frame_start=1.
- Default line: step one line.
  - hsync=0 for h_pos 0..95; hblank falls at h_pos=144 with x=0; x=639 at h_pos=783; hblank=1 at h_pos=784.
  - h_pos wraps 799→0 with v_pos 0→1; line_start is seen once per 1600 clks.
- Default frame:
  - vblank_start fires at v_pos=515, h_pos=0.
  - After h_pos=799, v_pos=524 the counters wrap to 0,0 and frame_start fires.
  - Period is 800*525*2 = 840000 clks.
- Small config: CLK_DIV=1, HSYNC_POL=1, VSYNC_POL=1, H=2/2/4/2, V=1/1/3/1.
  - pixel_en is constantly high; hsync=1 for h_pos 0..1; active for h_pos 4..7 on v_pos 2..4.
  - frame_start every 60 clks.
- Enable drop: deassert enable at h_pos=300, v_pos=100 for 3 clks.
  - Counters go to 0,0 and pixel_en=0.
  - On re-enable, frame_start occurs after CLK_DIV clks.
- Async reset: pulse _reset low mid-clk at v_pos=200.
  - Outputs return to reset values without waiting for a clk edge.
  - After release, the timing sequence restarts exactly as in the first scenario.
